traffic_phase_sequencer: RTL and testbench
==========================================

# traffic_phase_sequencer

Parametrised multi-approach traffic signal sequencer: the next generation of the single-approach controller. It drives NUM_PHASES signal heads in round-robin order, holding every head red except the one being served, with all-red clearance between phases. Optional pedestrian walk service is compiled in per build. It sits between the system clock/reset switch and the LED signal heads in the top-level netlist.

## Interface
- NUM_PHASES, 2: number of approaches served round-robin, legal 2..8.
- TIMER_W, 16: dwell timer width; every *_TIME must be in 1..2^TIMER_W-1.
- ALL_RED_TIME, 2000: cycles in ALL_RED clearance.
- RED_YELLOW_TIME, 5000: cycles in RED_YELLOW.
- GREEN_TIME, 20000: cycles in GREEN.
- YELLOW_TIME, 5000: cycles in YELLOW.
- WALK_TIME, 8000: cycles walk is shown at green start; must be ≤ GREEN_TIME.
- clk  input  1  clock, rising edge.
- reset  input  1  reset, synchronous, active-low.
- ped_req  input  NUM_PHASES  pedestrian request per approach, level, sampled each clk.
- R  output  NUM_PHASES  red lamp per approach.
- Y  output  NUM_PHASES  yellow lamp per approach.
- G  output  NUM_PHASES  green lamp per approach.
- walk  output  NUM_PHASES  pedestrian walk lamp per approach.
- phase  output  $clog2(NUM_PHASES)  index of approach currently served.

## Operation
- States: ALL_RED → RED_YELLOW → GREEN → YELLOW → ALL_RED; on YELLOW→ALL_RED, phase increments, wrapping NUM_PHASES-1 → 0.
- Dwell timer: loads X_TIME-1 on entry to state X, decrements each cycle; at 0 transitions next cycle. Each state lasts exactly X_TIME cycles.
- Lamps (Moore, decoded from registered state/phase only; no input→output combinational path):
  - Non-served approaches: R=1, Y=0, G=0 always.
  - Served approach: ALL_RED R=1; RED_YELLOW R=1,Y=1; GREEN G=1; YELLOW Y=1.
  - Exactly one approach may have G or Y set at any time; never two.
- Pedestrian service (see Configuration):
  - pending[i] sets on any cycle ped_req[i]=1; holds until serviced.
  - On the cycle of entry to GREEN for phase p, pending[p] is captured and cleared; a request arriving during that same cycle or later in the green stays pending for the next service of p.
  - If captured, walk[p]=1 for the first WALK_TIME cycles of GREEN; otherwise 0. walk is 0 in all other states.
- Reset (reset=0 at clk edge, overrides everything): state ALL_RED, phase 0, timer ALL_RED_TIME-1, pending all 0. Outputs after reset edge: R all 1, Y/G/walk all 0, phase 0.

## Timing
- One phase service = ALL_RED_TIME+RED_YELLOW_TIME+GREEN_TIME+YELLOW_TIME cycles; full rotation = NUM_PHASES times that.
- Lamp change visible the cycle after the timer reaches 0 (registered state).
- Reset mid-operation: next edge forces reset state regardless of current state, timer, or pending requests; a live lamp pattern drops to all-red in one cycle.
- ped_req to pending: 1 cycle. Request held across many cycles counts once.
- Timer never underflows; wrap-around of phase only at NUM_PHASES-1.

## Configuration
- PED_WALK_EN defined: pending register and walk logic built as above.
- PED_WALK_EN undefined: ped_req ignored, no pending storage, walk tied to 0; lamp sequencing identical.

## Test plan
Parameters for all: NUM_PHASES=2, ALL_RED=1, RED_YELLOW=1, GREEN=4, YELLOW=2, WALK=2.
- Reset 3 cycles then release → R=11, Y=G=00, phase=0; RY on approach 0 at cycle 1, G for cycles 2-5, Y for 6-7, phase=1 at cycle 8, rotation repeats every 16 cycles.
- Continuous run 100 cycles → G/Y never set on both approaches; non-served approach always R=1.
- ped_req[1] pulsed 1 cycle during phase 0 → walk[1]=1 for first 2 GREEN cycles of phase 1, then 0; no walk on next service of phase 1.
- ped_req[0] pulsed during phase 0's green cycle 3 → walk[0]=0 in current green, walk[0]=1 for 2 cycles in next phase 0 green.
- reset=0 asserted in GREEN cycle 2 of phase 1 → next cycle R=11, G=00, phase=0, pending cleared; sequence restarts from ALL_RED.
- Build without PED_WALK_EN, ped_req=11 constantly → walk=00 always, lamp trace identical to first scenario.

Source files
------------

// File: rtl/traffic_phase_sequencer.sv
// Round-robin multi-approach signal sequencer with all-red clearance between phases.
// Build option PED_WALK_EN adds per-approach pedestrian request latching and walk lamps.
module traffic_phase_sequencer #(
  parameter int NUM_PHASES      = 2,
  parameter int TIMER_W         = 16,
  parameter int ALL_RED_TIME    = 2000,
  parameter int RED_YELLOW_TIME = 5000,
  parameter int GREEN_TIME      = 20000,
  parameter int YELLOW_TIME     = 5000,
  parameter int WALK_TIME       = 8000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PHASES-1:0]         ped_req,
  output logic [NUM_PHASES-1:0]         R,
  output logic [NUM_PHASES-1:0]         Y,
  output logic [NUM_PHASES-1:0]         G,
  output logic [NUM_PHASES-1:0]         walk,
  output logic [$clog2(NUM_PHASES)-1:0] phase
);

  localparam int PW = $clog2(NUM_PHASES);

  localparam logic [1:0] ST_ALL_RED    = 2'd0;
  localparam logic [1:0] ST_RED_YELLOW = 2'd1;
  localparam logic [1:0] ST_GREEN      = 2'd2;
  localparam logic [1:0] ST_YELLOW     = 2'd3;

  localparam logic [TIMER_W-1:0] AR_LOAD    = TIMER_W'(ALL_RED_TIME - 1);
  localparam logic [TIMER_W-1:0] RY_LOAD    = TIMER_W'(RED_YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] G_LOAD     = TIMER_W'(GREEN_TIME - 1);
  localparam logic [TIMER_W-1:0] Y_LOAD     = TIMER_W'(YELLOW_TIME - 1);
  // Green timer counts down, so walk covers timer values at or above this mark.
  localparam logic [TIMER_W-1:0] WALK_LIMIT = TIMER_W'(GREEN_TIME - WALK_TIME);
  localparam logic [TIMER_W-1:0] TIMER_ZERO = {TIMER_W{1'b0}};
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [PW-1:0]      PHASE_LAST = PW'(NUM_PHASES - 1);
  localparam logic [PW-1:0]      PHASE_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]      PHASE_ONE  = PW'(1);
  localparam logic [NUM_PHASES-1:0] ALL_ONES  = {NUM_PHASES{1'b1}};
  localparam logic [NUM_PHASES-1:0] ALL_ZEROS = {NUM_PHASES{1'b0}};

  logic [1:0]            state_r, state_nx_s;
  logic [PW-1:0]         phase_r, phase_nx_s;
  logic [TIMER_W-1:0]    timer_r, timer_nx_s;
  logic [NUM_PHASES-1:0] red_r, yellow_r, green_r, walk_r;
  logic [NUM_PHASES-1:0] red_nx_s, yellow_nx_s, green_nx_s, walk_nx_s;
  logic                  enter_green_s;

  // Lamp pattern for a given state and served approach; all others stay red.
  function automatic logic [3*NUM_PHASES-1:0] decode_lamps(input logic [1:0] st,
                                                           input logic [PW-1:0] ph);
    logic [NUM_PHASES-1:0] r, y, g;
    r = ALL_ONES;
    y = ALL_ZEROS;
    g = ALL_ZEROS;
    case (st)
      ST_ALL_RED:    r = ALL_ONES;
      ST_RED_YELLOW: y[ph] = 1'b1;
      ST_GREEN: begin
        r[ph] = 1'b0;
        g[ph] = 1'b1;
      end
      ST_YELLOW: begin
        r[ph] = 1'b0;
        y[ph] = 1'b1;
      end
      default:       r = ALL_ONES;
    endcase
    return {r, y, g};
  endfunction

  // Next state, phase and dwell timer.
  always_comb begin
    state_nx_s = state_r;
    phase_nx_s = phase_r;
    timer_nx_s = timer_r;
    if (timer_r == TIMER_ZERO) begin
      case (state_r)
        ST_ALL_RED: begin
          state_nx_s = ST_RED_YELLOW;
          timer_nx_s = RY_LOAD;
        end
        ST_RED_YELLOW: begin
          state_nx_s = ST_GREEN;
          timer_nx_s = G_LOAD;
        end
        ST_GREEN: begin
          state_nx_s = ST_YELLOW;
          timer_nx_s = Y_LOAD;
        end
        ST_YELLOW: begin
          state_nx_s = ST_ALL_RED;
          timer_nx_s = AR_LOAD;
          phase_nx_s = (phase_r == PHASE_LAST) ? PHASE_ZERO : phase_r + PHASE_ONE;
        end
        default: begin
          state_nx_s = ST_ALL_RED;
          timer_nx_s = AR_LOAD;
          phase_nx_s = PHASE_ZERO;
        end
      endcase
    end else begin
      timer_nx_s = timer_r - TIMER_ONE;
    end
  end

  assign enter_green_s = (state_r == ST_RED_YELLOW) && (timer_r == TIMER_ZERO);

  // Lamps are decoded from the next state so they register alongside it.
  always_comb begin
    {red_nx_s, yellow_nx_s, green_nx_s} = decode_lamps(state_nx_s, phase_nx_s);
  end

`ifdef PED_WALK_EN
  logic [NUM_PHASES-1:0] pending_r, pending_nx_s, served_mask_s;
  logic                  cap_r, cap_nx_s;

  assign served_mask_s = ALL_ZEROS | (NUM_PHASES'(1) << phase_r);

  // Latch requests; the served approach's request is captured on green entry.
  always_comb begin
    pending_nx_s = pending_r | ped_req;
    cap_nx_s     = cap_r;
    if (enter_green_s) begin
      cap_nx_s     = pending_r[phase_r];
      pending_nx_s = (pending_r & ~served_mask_s) | ped_req;
    end else begin
      cap_nx_s     = cap_r;
    end
  end

  // Walk shows only during the opening WALK_TIME cycles of a captured green.
  always_comb begin
    walk_nx_s = ALL_ZEROS;
    if (cap_nx_s && (state_nx_s == ST_GREEN) && (timer_nx_s >= WALK_LIMIT)) begin
      walk_nx_s[phase_nx_s] = 1'b1;
    end else begin
      walk_nx_s = ALL_ZEROS;
    end
  end

  // Pedestrian request storage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_r <= ALL_ZEROS;
      cap_r     <= 1'b0;
    end else begin
      pending_r <= pending_nx_s;
      cap_r     <= cap_nx_s;
    end
  end
`else
  logic unused_ped_s;
  logic unused_green_s;

  assign unused_ped_s   = ^ped_req;
  assign unused_green_s = enter_green_s ^ (^WALK_LIMIT);
  assign walk_nx_s      = ALL_ZEROS;
`endif

  // Sequencer state and registered lamp outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= ST_ALL_RED;
      phase_r  <= PHASE_ZERO;
      timer_r  <= AR_LOAD;
      red_r    <= ALL_ONES;
      yellow_r <= ALL_ZEROS;
      green_r  <= ALL_ZEROS;
      walk_r   <= ALL_ZEROS;
    end else begin
      state_r  <= state_nx_s;
      phase_r  <= phase_nx_s;
      timer_r  <= timer_nx_s;
      red_r    <= red_nx_s;
      yellow_r <= yellow_nx_s;
      green_r  <= green_nx_s;
      walk_r   <= walk_nx_s;
    end
  end

  assign R     = red_r;
  assign Y     = yellow_r;
  assign G     = green_r;
  assign walk  = walk_r;
  assign phase = phase_r;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: cycle-count reference model of the rotation
// and pedestrian service, randomized requests, directed boundary scenarios.
module tb_traffic_phase_sequencer;

  localparam int N   = 2;
  localparam int AR  = 1;
  localparam int RYT = 1;
  localparam int GT  = 4;
  localparam int YT  = 2;
  localparam int WT  = 2;
  localparam int SVC = AR + RYT + GT + YT;
`ifdef PED_WALK_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] ped_req = '0;
  logic [N-1:0] R, Y, G, walk;
  logic [0:0]   phase;

  traffic_phase_sequencer #(
    .NUM_PHASES(N), .TIMER_W(8), .ALL_RED_TIME(AR), .RED_YELLOW_TIME(RYT),
    .GREEN_TIME(GT), .YELLOW_TIME(YT), .WALK_TIME(WT)
  ) dut (
    .clk(clk), .reset(reset), .ped_req(ped_req),
    .R(R), .Y(Y), .G(G), .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles since reset, pending requests, captured flag.
  int           t = 0;
  logic [N-1:0] pend = '0;
  logic         cap = 1'b0;
  logic [N-1:0] exp_R, exp_Y, exp_G, exp_walk;
  logic [0:0]   exp_phase;

  task automatic step();
    logic         r;
    logic [N-1:0] q;
    int k, p;
    r = reset;
    q = ped_req;
    @(posedge clk);
    #1;
    if (!r) begin
      t = 0; pend = '0; cap = 1'b0;
    end else begin
      t = t + 1;
      k = t % SVC;
      p = (t / SVC) % N;
      if (k == AR + RYT) begin
        cap = pend[p];
        pend[p] = 1'b0;
      end
      pend = pend | q;
    end
    k = t % SVC;
    p = (t / SVC) % N;
    exp_R = '1; exp_Y = '0; exp_G = '0; exp_walk = '0;
    exp_phase = 1'(p);
    if (k < AR) begin
      exp_R = '1;
    end else if (k < AR + RYT) begin
      exp_Y[p] = 1'b1;
    end else if (k < AR + RYT + GT) begin
      exp_R[p] = 1'b0;
      exp_G[p] = 1'b1;
      if (PED && cap && (k - (AR + RYT)) < WT) exp_walk[p] = 1'b1;
    end else begin
      exp_R[p] = 1'b0;
      exp_Y[p] = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    ped_req = '0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({R, Y, G, walk, phase} !== {2'b11, 2'b00, 2'b00, 2'b00, 1'b0}) begin
        errors++;
        $display("FAIL reset cyc%0d: R=%b Y=%b G=%b walk=%b phase=%0d, want R=11 Y=00 G=00 walk=00 phase=0",
                 i, R, Y, G, walk, phase);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_sequence();
    logic [N-1:0] g_trace [0:15];
    for (int i = 1; i <= 16; i++) begin
      step();
      g_trace[i-1] = G;
      checks++;
      if ({R, Y, G, walk, phase} !== {exp_R, exp_Y, exp_G, exp_walk, exp_phase}) begin
        errors++;
        $display("FAIL sequence t=%0d: R=%b Y=%b G=%b walk=%b ph=%0d, want R=%b Y=%b G=%b walk=%b ph=%0d",
                 t, R, Y, G, walk, phase, exp_R, exp_Y, exp_G, exp_walk, exp_phase);
      end
      if (i == 8) begin
        checks++;
        if (phase !== 1'b1) begin
          errors++;
          $display("FAIL phase_wrap_at_8: phase=%0d, want 1", phase);
        end
      end
    end
    checks++;
    if ({g_trace[1], g_trace[4], g_trace[5], g_trace[9], g_trace[15]} !== {2'b01, 2'b01, 2'b00, 2'b10, 2'b00}) begin
      errors++;
      $display("FAIL green_trace: got %b %b %b %b %b, want 01 01 00 10 00",
               g_trace[1], g_trace[4], g_trace[5], g_trace[9], g_trace[15]);
    end
  endtask

  task automatic test_exclusive();
    for (int i = 0; i < 100; i++) begin
      ped_req = N'($urandom_range(0, 3));
      step();
      checks++;
      if ($countones(G | Y) > 1 || R[~phase] !== 1'b1) begin
        errors++;
        $display("FAIL exclusive t=%0d: G=%b Y=%b R=%b phase=%0d", t, G, Y, R, phase);
      end
      checks++;
      if ({R, Y, G, walk, phase} !== {exp_R, exp_Y, exp_G, exp_walk, exp_phase}) begin
        errors++;
        $display("FAIL model t=%0d: R=%b Y=%b G=%b walk=%b ph=%0d, want R=%b Y=%b G=%b walk=%b ph=%0d",
                 t, R, Y, G, walk, phase, exp_R, exp_Y, exp_G, exp_walk, exp_phase);
      end
    end
    ped_req = '0;
  endtask

  task automatic test_ped_phase1();
    int first, second;
    first = 0; second = 0;
    do_reset();
    step();
    ped_req = 2'b10;
    step();
    ped_req = 2'b00;
    while (t < 2 * SVC + 2 * N * SVC) begin
      step();
      if (t < N * SVC) first += int'(walk[1]);
      else second += int'(walk[1]);
      checks++;
      if (walk !== exp_walk) begin
        errors++;
        $display("FAIL ped1_walk t=%0d: walk=%b, want %b", t, walk, exp_walk);
      end
    end
    checks++;
    if (first !== (PED ? 2 : 0) || second !== 0) begin
      errors++;
      $display("FAIL ped1_count: first=%0d second=%0d, want %0d and 0", first, second, PED ? 2 : 0);
    end
  endtask

  task automatic test_ped_green3();
    int cur, nxt;
    cur = 0; nxt = 0;
    do_reset();
    while (t < AR + RYT + 2) step();
    ped_req = 2'b01;
    step();
    ped_req = 2'b00;
    cur += int'(walk[0]);
    while (t < N * SVC + SVC - 1) begin
      step();
      if (t < SVC) cur += int'(walk[0]);
      else if (t >= N * SVC) nxt += int'(walk[0]);
      checks++;
      if (walk !== exp_walk) begin
        errors++;
        $display("FAIL ped0_walk t=%0d: walk=%b, want %b", t, walk, exp_walk);
      end
    end
    checks++;
    if (cur !== 0 || nxt !== (PED ? 2 : 0)) begin
      errors++;
      $display("FAIL ped0_count: current=%0d next=%0d, want 0 and %0d", cur, nxt, PED ? 2 : 0);
    end
  endtask

  task automatic test_mid_reset();
    int w0;
    w0 = 0;
    do_reset();
    ped_req = 2'b01;
    step();
    ped_req = 2'b00;
    while (t < SVC + AR + RYT + 1) step();
    checks++;
    if (G !== 2'b10) begin
      errors++;
      $display("FAIL pre_reset_green: G=%b, want 10", G);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({R, Y, G, walk, phase} !== {2'b11, 2'b00, 2'b00, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: R=%b Y=%b G=%b walk=%b phase=%0d, want 11 00 00 00 0", R, Y, G, walk, phase);
    end
    reset = 1'b1;
    for (int i = 0; i < SVC; i++) begin
      step();
      w0 += int'(walk[0]);
      checks++;
      if ({R, Y, G, walk, phase} !== {exp_R, exp_Y, exp_G, exp_walk, exp_phase}) begin
        errors++;
        $display("FAIL restart t=%0d: R=%b Y=%b G=%b walk=%b ph=%0d, want R=%b Y=%b G=%b walk=%b ph=%0d",
                 t, R, Y, G, walk, phase, exp_R, exp_Y, exp_G, exp_walk, exp_phase);
      end
    end
    checks++;
    if (w0 !== 0) begin
      errors++;
      $display("FAIL pending_cleared: walk0 cycles=%0d, want 0", w0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      ped_req = ($urandom_range(0, 5) == 0) ? N'($urandom_range(1, 3)) : 2'b00;
      reset = ($urandom_range(0, 60) == 0) ? 1'b0 : 1'b1;
      step();
      checks++;
      if ({R, Y, G, walk, phase} !== {exp_R, exp_Y, exp_G, exp_walk, exp_phase}) begin
        errors++;
        $display("FAIL random t=%0d: R=%b Y=%b G=%b walk=%b ph=%0d, want R=%b Y=%b G=%b walk=%b ph=%0d",
                 t, R, Y, G, walk, phase, exp_R, exp_Y, exp_G, exp_walk, exp_phase);
      end
    end
    reset = 1'b1;
    ped_req = '0;
  endtask

  initial begin
    #2;
    test_reset();
    test_sequence();
    test_exclusive();
    test_ped_phase1();
    test_ped_green3();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
